frac_logic_k: RTL and testbench

FRAC_LOGIC_K -- requirements
Module: frac_logic_k

---
 rtl/frac_logic_k.sv | 98 +++++++++
 tb/tb_frac_logic_k.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frac_logic_k.sv
// frac_logic_k: fracturable K-input LUT with a serial configuration chain.
// The chain holds 2^K LUT bits followed by a 2-bit mode field; the last chain
// bit drives ccff_tail so instances can be cascaded into one shift register.
// Optional feature: define FRAC_LOGIC_READBACK_EN to add the ccff_rotate input,
// which recirculates the chain for non-destructive readback on ccff_tail.
module frac_logic_k #(
  parameter int unsigned K = 4
) (
  input  logic         prog_clk,
  input  logic         prog_reset_n,
  input  logic         ccff_head,
  input  logic         ccff_en,
`ifdef FRAC_LOGIC_READBACK_EN
  input  logic         ccff_rotate,
`endif
  input  logic [K-1:0] frac_logic_in,
  output logic [1:0]   frac_logic_out,
  output logic         ccff_tail,
  output logic         config_done
);

  localparam int unsigned LutSize   = 2 ** K;
  localparam int unsigned CHAIN_LEN = LutSize + 2;
  localparam int unsigned CntW      = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] mem_q, mem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 rotate;

`ifdef FRAC_LOGIC_READBACK_EN
  assign rotate = ccff_rotate;
`else
  assign rotate = 1'b0;
`endif

  // Next-state: shift in ccff_head (counting up to CHAIN_LEN) or rotate.
  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (ccff_en) begin
      if (rotate) begin
        // Recirculate; programming progress is left untouched.
        mem_d = {mem_q[CHAIN_LEN-2:0], mem_q[CHAIN_LEN-1]};
      end else begin
        mem_d = {mem_q[CHAIN_LEN-2:0], ccff_head};
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (cnt_d == CntMax) begin
          done_d = 1'b1;
        end
      end
    end
  end

  // Configuration state, cleared asynchronously by prog_reset_n.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      mem_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign ccff_tail   = mem_q[CHAIN_LEN-1];
  assign config_done = done_q;

  logic [LutSize-1:0] lut;
  logic [1:0]         mode;
  logic [K-2:0]       addr;
  logic               lo, hi, full, out0_raw;

  assign lut  = mem_q[LutSize-1:0];
  assign mode = mem_q[CHAIN_LEN-1 -: 2];
  assign addr = frac_logic_in[K-2:0];
  assign lo   = lut[{1'b0, addr}];
  assign hi   = lut[{1'b1, addr}];
  assign full = frac_logic_in[K-1] ? hi : lo;

  // Output select by mode; outputs stay quiet until the chain is fully loaded.
  always_comb begin
    out0_raw = 1'b0;
    case (mode)
      2'b00:   out0_raw = lo;
      2'b10:   out0_raw = 1'b0;
      default: out0_raw = full;
    endcase
    frac_logic_out = done_q ? {hi, out0_raw} : 2'b00;
  end

endmodule

// File: tb/tb_frac_logic_k.sv
// Directed self-checking bench for frac_logic_k with K=4 (CHAIN_LEN=18).
module tb_frac_logic_k;

  logic       prog_clk = 1'b0;
  logic       prog_reset_n;
  logic       ccff_head;
  logic       ccff_en;
`ifdef FRAC_LOGIC_READBACK_EN
  logic       ccff_rotate;
`endif
  logic [3:0] frac_logic_in;
  logic [1:0] frac_logic_out;
  logic       ccff_tail;
  logic       config_done;

  int checks   = 0;
  int failures = 0;

  frac_logic_k #(.K(4)) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .ccff_head     (ccff_head),
    .ccff_en       (ccff_en),
`ifdef FRAC_LOGIC_READBACK_EN
    .ccff_rotate   (ccff_rotate),
`endif
    .frac_logic_in (frac_logic_in),
    .frac_logic_out(frac_logic_out),
    .ccff_tail     (ccff_tail),
    .config_done   (config_done)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge after one shift.
  task automatic shift_bit(input logic b);
    ccff_head = b;
    ccff_en   = 1'b1;
    @(negedge prog_clk);
    ccff_en   = 1'b0;
  endtask

  // Mode bit 1 goes in first so it lands in mem[17]; lut[0] goes in last.
  task automatic program_cfg(input logic [1:0] mode, input logic [15:0] lut);
    logic [17:0] p;
    p = {mode, lut};
    for (int i = 17; i >= 0; i--) shift_bit(p[i]);
  endtask

  task automatic apply_in(input logic [3:0] v);
    frac_logic_in = v;
    #1;
  endtask

  logic [15:0] lut_a;
  logic [17:0] pat;
  logic [3:0]  iv;

  initial begin
    prog_reset_n  = 1'b0;
    ccff_head     = 1'b0;
    ccff_en       = 1'b0;
`ifdef FRAC_LOGIC_READBACK_EN
    ccff_rotate   = 1'b0;
`endif
    frac_logic_in = 4'hF;
    lut_a         = 16'hA5C3;

    // Reset state, with clocks and a shifting request held off by reset.
    ccff_en   = 1'b1;
    ccff_head = 1'b1;
    repeat (3) @(negedge prog_clk);
    ccff_en = 1'b0;
    check_eq("rst_done", 32'(config_done), 32'd0);
    check_eq("rst_out", 32'(frac_logic_out), 32'd0);
    check_eq("rst_tail", 32'(ccff_tail), 32'd0);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);

    // 17 ones: not yet configured, outputs forced low; 18th completes.
    for (int i = 0; i < 17; i++) shift_bit(1'b1);
    check_eq("ones17_done", 32'(config_done), 32'd0);
    check_eq("ones17_out", 32'(frac_logic_out), 32'd0);
    shift_bit(1'b1);
    check_eq("ones18_done", 32'(config_done), 32'd1);
    check_eq("ones18_out", 32'(frac_logic_out), 32'd3);
    check_eq("ones18_tail", 32'(ccff_tail), 32'd1);

    // AND4 in mode 01: out0 only at 1111; out1=hi=lut[8+A] so also at 0111.
    program_cfg(2'b01, 16'h8000);
    check_eq("and4_done", 32'(config_done), 32'd1);
    check_eq("and4_tail", 32'(ccff_tail), 32'd0);
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      apply_in(iv);
      check_eq($sformatf("and4_o0_%0d", i), 32'(frac_logic_out[0]), 32'(i == 15));
      check_eq($sformatf("and4_o1_%0d", i), 32'(frac_logic_out[1]), 32'(iv[2:0] == 3'd7));
      @(negedge prog_clk);
    end

    // Hold: ccff_en low, ccff_head toggling, nothing changes.
    for (int i = 0; i < 4; i++) begin
      ccff_head = ~ccff_head;
      @(negedge prog_clk);
    end
    apply_in(4'hF);
    check_eq("hold_out_f", 32'(frac_logic_out), 32'd3);
    apply_in(4'h7);
    check_eq("hold_out_7", 32'(frac_logic_out), 32'd2);
    check_eq("hold_tail", 32'(ccff_tail), 32'd0);
    @(negedge prog_clk);

    // Mode 00, lut 6996: out0 = XOR3, out1 = XNOR3, in[3] ignored.
    program_cfg(2'b00, 16'h6996);
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      apply_in(iv);
      check_eq($sformatf("xor_o0_%0d", i), 32'(frac_logic_out[0]), 32'(^iv[2:0]));
      check_eq($sformatf("xor_o1_%0d", i), 32'(frac_logic_out[1]), 32'(~^iv[2:0]));
      @(negedge prog_clk);
    end

    // Mode 10: out0 constant 0, out1 = hi.
    program_cfg(2'b10, lut_a);
    check_eq("m10_tail", 32'(ccff_tail), 32'd1);
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      apply_in(iv);
      check_eq($sformatf("m10_o0_%0d", i), 32'(frac_logic_out[0]), 32'd0);
      check_eq($sformatf("m10_o1_%0d", i), 32'(frac_logic_out[1]),
               32'(lut_a[{1'b1, iv[2:0]}]));
      @(negedge prog_clk);
    end

    // Mode 11: out0 = full 4-input LUT, counter long past saturation.
    program_cfg(2'b11, lut_a);
    check_eq("m11_done", 32'(config_done), 32'd1);
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      apply_in(iv);
      check_eq($sformatf("m11_o0_%0d", i), 32'(frac_logic_out[0]), 32'(lut_a[iv]));
      @(negedge prog_clk);
    end

    // Reset after 9 shifts discards progress; count restarts at 0.
    prog_reset_n = 1'b0;
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    for (int i = 0; i < 9; i++) shift_bit(1'b1);
    check_eq("part9_done", 32'(config_done), 32'd0);
    prog_reset_n = 1'b0;
    #1;
    check_eq("mid_rst_tail", 32'(ccff_tail), 32'd0);
    check_eq("mid_rst_done", 32'(config_done), 32'd0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    pat = {2'b00, 16'h6996};
    for (int i = 17; i >= 1; i--) shift_bit(pat[i]);
    check_eq("rs17_done", 32'(config_done), 32'd0);
    apply_in(4'h1);
    check_eq("rs17_out", 32'(frac_logic_out), 32'd0);
    shift_bit(pat[0]);
    check_eq("rs18_done", 32'(config_done), 32'd1);
    check_eq("rs18_tail", 32'(ccff_tail), 32'd0);
    apply_in(4'h1);
    check_eq("rs18_out_1", 32'(frac_logic_out), 32'd1);
    apply_in(4'h3);
    check_eq("rs18_out_3", 32'(frac_logic_out), 32'd2);
    apply_in(4'hF);
    check_eq("rs18_out_f", 32'(frac_logic_out), 32'd1);
    @(negedge prog_clk);

`ifdef FRAC_LOGIC_READBACK_EN
    // Rotate readback: tail streams the pattern in shift order, then restored.
    pat = {2'b11, lut_a};
    program_cfg(2'b11, lut_a);
    for (int i = 17; i >= 0; i--) begin
      check_eq($sformatf("rot_tail_%0d", 17 - i), 32'(ccff_tail), 32'(pat[i]));
      ccff_rotate = 1'b1;
      shift_bit(~pat[i]);
      ccff_rotate = 1'b0;
    end
    check_eq("rot_done", 32'(config_done), 32'd1);
    check_eq("rot_tail_end", 32'(ccff_tail), 32'(pat[17]));
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      apply_in(iv);
      check_eq($sformatf("rot_o_%0d", i), 32'(frac_logic_out),
               32'({lut_a[{1'b1, iv[2:0]}], lut_a[iv]}));
      @(negedge prog_clk);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
